sub_unit: RTL and testbench
===========================

SUB_UNIT -- requirements
Module: sub_unit

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, meaning the width of the reservation-station tag carried alongside each operation.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1, which discards all in-flight operations.
REQ-005 The block SHALL have port in_valid, input, 1, indicating the operand pair is valid.
REQ-006 The block SHALL have port in_ready, output, 1, indicating the block accepts the operand pair this cycle.
REQ-007 The block SHALL have ports in_a and in_b, input, 32 each, the minuend and subtrahend.
REQ-008 The block SHALL have port in_tag, input, TAG_W, the destination tag.
REQ-009 The block SHALL have port out_valid, output, 1, indicating the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, indicating the consumer (CDB arbiter) accepts the result.
REQ-011 The block SHALL have port out_diff, output, 32, carrying a minus b modulo 2^32.
REQ-012 The block SHALL have port out_borrow, output, 1, set when a is less than b unsigned.
REQ-013 The block SHALL have port out_ovf, output, 1, the signed-overflow flag.
REQ-014 The block SHALL have port out_tag, output, TAG_W, the tag of the result.

Function
REQ-015 Two-stage pipeline SHALL be used: S1 registers diff[15:0], the carry out of bit 15, the upper operand halves and the tag; S2 registers diff[31:16], borrow, ovf and the tag.
REQ-016 Subtraction SHALL be computed as a + ~b + 1; borrow SHALL equal the inverted carry out of bit 31; ovf SHALL equal (a[31]!=b[31]) && (diff[31]!=a[31]).
REQ-017 Transfer SHALL occur on in_valid&&in_ready, or on out_valid&&out_ready; latency SHALL be exactly 2 cycles from accept to out_valid when there is no stall.
REQ-018 S2 SHALL advance when !s2_valid || out_ready; S1 SHALL advance when !s1_valid || S2 advances; in_ready SHALL equal the S1 advance condition, combinationally, with no dependence on in_valid.
REQ-019 Throughput SHALL be one operation per cycle with out_ready held high; with out_ready low, two results SHALL be held and a third SHALL NOT be accepted.
REQ-020 Outputs SHALL be held stable while out_valid && !out_ready.
REQ-021 On flush, both valid bits SHALL clear on the next edge, and an input presented in the flush cycle SHALL be dropped; in_ready SHALL be 0 during flush.
REQ-022 flush SHALL take priority over a simultaneous accept or output transfer; the output transfer in that cycle still counts as delivered.

Reset
REQ-023 With rst_n low at an edge, s1_valid, s2_valid and out_valid SHALL be 0, out_diff, out_borrow, out_ovf and out_tag SHALL be 0, and in_ready SHALL be 0 while rst_n is low.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight results with no output.

Configuration
REQ-025 With macro SUB_UNIT_OVF_EN defined, out_ovf SHALL be computed per REQ-016.
REQ-026 With SUB_UNIT_OVF_EN undefined, out_ovf SHALL be tied 0, no overflow state SHALL be registered, and the port list SHALL be unchanged.

Structure
REQ-027 The shared package SHALL hold DATA_W=32, HALF_W=16 and the default TAG_W, shared with the adder and the reservation stations.
REQ-028 One sub-module, sub_half_stage (a 16-bit a+~b+cin slice with carry-out), SHALL be instantiated twice, once per stage.

Verification
REQ-029 a=5, b=3, tag=2 -> 2 cycles later out_diff=2, borrow=0, ovf=0, out_tag=2.
REQ-030 a=0, b=1 -> out_diff=0xFFFFFFFF, borrow=1, ovf=0; a=0x80000000, b=1 -> out_diff=0x7FFFFFFF, ovf=1 (0 when the macro is undefined).
REQ-031 Back-to-back 8 ops with out_ready=1 -> 8 results on consecutive cycles, in order, with matching tags.
REQ-032 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, in_ready=0 afterwards, and outputs stable until out_ready=1.
REQ-033 flush with both stages full plus in_valid=1 -> no out_valid for the next 3 cycles; the next accepted op returns its correct result 2 cycles later.
REQ-034 rst_n low for 1 cycle with the pipeline full -> all outputs 0 and out_valid=0 after the edge, with no stale results afterwards.

Source files
------------

// File: rtl/sub_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sub_unit_pkg
//  Purpose  : Shared widths for the integer execution units and reservation
//             stations, plus the signed-overflow helper used by sub_unit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sub_unit_pkg;

    localparam int DATA_W        = 32;
    localparam int HALF_W        = 16;
    localparam int TAG_W_DEFAULT = 4;

    // Signed overflow of a - b: operands of opposite sign and a result whose
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_half_stage.sv
`default_nettype none
// ============================================================================
//  Module   : sub_half_stage
//  Purpose  : 16-bit subtract slice computing a + ~b + cin with carry-out.
//  Ports    : a, b  - 16-bit operands (b is inverted internally)
//             cin   - carry in (1 for the low slice, chained carry otherwise)
//             diff  - 16-bit result
//             cout  - carry out of the slice MSB
//  Revision : 1.0 - initial release
// ============================================================================
module sub_half_stage
    import sub_unit_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] diff,
    output logic              cout
);

    logic [HALF_W:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, ~b} + {{HALF_W{1'b0}}, cin};
    assign diff  = w_sum[HALF_W-1:0];
    assign cout  = w_sum[HALF_W];

endmodule
`default_nettype wire

// File: rtl/sub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sub_unit
//  Purpose  : Two-stage pipelined 32-bit subtractor with valid/ready handshake
//             on both sides, tag pass-through and flush.
//             Stage 1 computes the low half, stage 2 the high half and flags.
//  Macro    : SUB_UNIT_OVF_EN - when defined, out_ovf carries the signed
//             overflow flag; otherwise out_ovf is tied 0 (ports unchanged).
//  Ports    : clk, rst_n (sync, active-low), flush
//             in_valid/in_ready, in_a, in_b, in_tag      - operand side
//             out_valid/out_ready, out_diff, out_borrow,
//             out_ovf, out_tag                           - result side
//  Revision : 1.0 - initial release
// ============================================================================
module sub_unit
    import sub_unit_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_diff,
    output logic              out_borrow,
    output logic              out_ovf,
    output logic [TAG_W-1:0]  out_tag
);

    // Stage 1 state
    logic              r_s1_valid;
    logic [HALF_W-1:0] r_s1_diff_lo;
    logic              r_s1_carry;
    logic [HALF_W-1:0] r_s1_a_hi;
    logic [HALF_W-1:0] r_s1_b_hi;
    logic [TAG_W-1:0]  r_s1_tag;

    // Stage 2 state
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_diff;
    logic              r_s2_borrow;
    logic [TAG_W-1:0]  r_s2_tag;

    logic [HALF_W-1:0] w_lo_diff;
    logic              w_lo_carry;
    logic [HALF_W-1:0] w_hi_diff;
    logic              w_hi_carry;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_accept;

    sub_half_stage u_lo (
        .a    (in_a[HALF_W-1:0]),
        .b    (in_b[HALF_W-1:0]),
        .cin  (1'b1),
        .diff (w_lo_diff),
        .cout (w_lo_carry)
    );

    sub_half_stage u_hi (
        .a    (r_s1_a_hi),
        .b    (r_s1_b_hi),
        .cin  (r_s1_carry),
        .diff (w_hi_diff),
        .cout (w_hi_carry)
    );

    // Backpressure chain: a stage may load when it is empty or when the
    // stage downstream of it is moving this cycle.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = rst_n && !flush && w_s1_adv;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_diff_lo <= '0;
            r_s1_carry   <= 1'b0;
            r_s1_a_hi    <= '0;
            r_s1_b_hi    <= '0;
            r_s1_tag     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_diff    <= '0;
            r_s2_borrow  <= 1'b0;
            r_s2_tag     <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only the valid bits matter.
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_diff_lo <= w_lo_diff;
                    r_s1_carry   <= w_lo_carry;
                    r_s1_a_hi    <= in_a[DATA_W-1:HALF_W];
                    r_s1_b_hi    <= in_b[DATA_W-1:HALF_W];
                    r_s1_tag     <= in_tag;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_diff   <= {w_hi_diff, r_s1_diff_lo};
                    // No carry out of bit 31 means the subtraction borrowed.
                    r_s2_borrow <= !w_hi_carry;
                    r_s2_tag    <= r_s1_tag;
                end
            end
        end
    end

`ifdef SUB_UNIT_OVF_EN
    logic r_s2_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_ovf <= 1'b0;
        end else if (!flush && w_s2_adv && r_s1_valid) begin
            r_s2_ovf <= sub_ovf(r_s1_a_hi[HALF_W-1], r_s1_b_hi[HALF_W-1],
                                w_hi_diff[HALF_W-1]);
        end
    end

    assign out_ovf = r_s2_ovf;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid  = r_s2_valid;
    assign out_diff   = r_s2_diff;
    assign out_borrow = r_s2_borrow;
    assign out_tag    = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_sub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub_unit
//  Purpose  : Self-checking bench for sub_unit. Table vectors and random ops
//             feed a scoreboard queue; a negedge monitor pops and compares
//             every delivered result. Hand sequences cover latency, stall,
//             flush and mid-operation reset.
//  Macro    : SUB_UNIT_OVF_EN - selects the expected out_ovf behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sub_unit;

    localparam int TW = 4;
`ifdef SUB_UNIT_OVF_EN
    localparam logic C_OVF = 1'b1;
`else
    localparam logic C_OVF = 1'b0;
`endif

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
        logic [31:0]   d;
        logic          bo;
        logic          ov;
    } vec_t;

    typedef struct {
        logic [31:0]   d;
        logic          bo;
        logic          ov;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_a, in_b, out_diff;
    logic [TW-1:0] in_tag, out_tag;
    logic          out_borrow, out_ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_pops = 0;
    int   first_pop = -1;
    int   last_pop = -1;
    bit   rnd_ready = 1'b0;
    exp_t q[$];
    vec_t tbl[8];

    sub_unit #(.TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: a transfer seen at negedge completes at next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got diff %0h tag %0h, required no output",
                             out_diff, out_tag);
                end else begin
                    e = q.pop_front();
                    check("out_diff", out_diff, e.d);
                    check("out_borrow", {31'd0, out_borrow}, {31'd0, e.bo});
                    check("out_ovf", {31'd0, out_ovf}, {31'd0, e.ov});
                    check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
                end
            end
            if (flush) q.delete();
        end
    end

    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [TW-1:0] tag);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.tag = tag;
        v.d   = a - b;
        v.bo  = (a < b);
        v.ov  = C_OVF & (a[31] != b[31]) & (v.d[31] != a[31]);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for acceptance, push its expectation.
    task automatic send(input vec_t v, output int acc_cyc);
        int n = 0;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_tag   = v.tag;
        acc_cyc  = -1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{d: v.d, bo: v.bo, ov: v.ov, tag: v.tag});
                acc_cyc = cyc;
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", n);
                break;
            end
            step();
        end
        step();
    endtask

    task automatic reset_pops();
        n_pops = 0;
        first_pop = -1;
        last_pop = -1;
    endtask

    initial begin
        int   acc, acc0, n_acc, idx;
        vec_t v;
        logic [31:0] snap_d;
        logic [TW-1:0] snap_t;
        logic snap_ok;

        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 4'd2,  32'h0000_0002, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0000_0001, 4'd3,  32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h0000_0001, 4'd4,  32'h7FFF_FFFF, 1'b0, C_OVF};
        tbl[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd5,  32'h8000_0000, 1'b1, C_OVF};
        tbl[4] = '{32'h1234_5678, 32'h1234_5678, 4'd6,  32'h0000_0000, 1'b0, 1'b0};
        tbl[5] = '{32'h0001_0000, 32'h0000_0001, 4'd7,  32'h0000_FFFF, 1'b0, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 4'd8,  32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 4'd15, 32'h0000_0000, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_diff", out_diff, 32'd0);
        check("rst_out_flags", {30'd0, out_borrow, out_ovf}, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Single op: latency of exactly two cycles
        send(tbl[0], acc);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        @(negedge clk);
        check("lat_cycle2_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) step();

        // Back-to-back table ops with out_ready high
        reset_pops();
        acc0 = -1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i], acc);
            if (i == 0) acc0 = acc;
        end
        in_valid = 1'b0;
        repeat (5) step();
        check("b2b_count", n_pops, 8);
        check("b2b_consecutive", last_pop - first_pop, 7);
        check("b2b_latency", first_pop - acc0, 2);

        // Stall: out_ready low for 5 cycles while offering ops
        out_ready = 1'b0;
        n_acc = 0;
        idx = 0;
        snap_ok = 1'b0;
        snap_d = '0;
        snap_t = '0;
        for (int k = 0; k < 5; k++) begin
            v = model(32'h100 + 32'(idx), 32'h10, 4'(idx + 1));
            in_valid = 1'b1;
            in_a = v.a; in_b = v.b; in_tag = v.tag;
            @(negedge clk);
            if (snap_ok) begin
                check("stall_hold_diff", out_diff, snap_d);
                check("stall_hold_tag", {28'd0, out_tag}, {28'd0, snap_t});
            end else if (out_valid) begin
                snap_ok = 1'b1;
                snap_d = out_diff;
                snap_t = out_tag;
            end
            if (in_ready) begin
                q.push_back('{d: v.d, bo: v.bo, ov: v.ov, tag: v.tag});
                n_acc++;
                idx++;
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_accepted", n_acc, 2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_diff", out_diff, 32'h0000_00F0);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        check("stall_drained", q.size(), 0);

        // Flush with both stages full and an input offered
        out_ready = 1'b0;
        send(model(32'd50, 32'd7, 4'd9), acc);
        send(model(32'd60, 32'd7, 4'd10), acc);
        flush = 1'b1;
        in_valid = 1'b1;
        in_a = 32'd99; in_b = 32'd1; in_tag = 4'd11;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_no_out", {31'd0, out_valid}, 32'd0);
            step();
        end
        reset_pops();
        send(model(32'hDEAD_0000, 32'h0000_BEEF, 4'd12), acc);
        in_valid = 1'b0;
        repeat (3) step();
        check("post_flush_count", n_pops, 1);
        check("post_flush_latency", first_pop - acc, 2);

        // Reset with the pipeline full
        out_ready = 1'b0;
        send(model(32'd1000, 32'd1, 4'd13), acc);
        send(model(32'd2000, 32'd2, 4'd14), acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_diff", out_diff, 32'd0);
        check("midrst_out_flags", {30'd0, out_borrow, out_ovf}, 32'd0);
        check("midrst_out_tag", {28'd0, out_tag}, 32'd0);
        reset_pops();
        repeat (4) step();
        check("midrst_no_stale", n_pops, 0);

        // Random ops with random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(model($urandom, (i % 3 == 0) ? 32'h8000_0000 : $urandom, 4'($urandom)), acc);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (4) step();
        check("random_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
